mem_stage_ctrl: RTL and testbench

Memory-stage controller that consumes the EXE/MEM pipeline register outputs of the 8-bit pipelined core.
- Passes ALU results straight to the MEM/WB boundary.
- Executes loads and stores against a multi-cycle data memory over a req/ack handshake.
- Stalls upstream stages while an access is outstanding.
- Aborts an access on timeout.
- Registers the MEM/WB fields: regWr, rd, write-back data.

---
 rtl/mem_stage_ctrl_if.sv | 53 +++++
 rtl/mem_stage_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl_if
// Bundles the EXE/MEM inputs, the data-memory req/ack bus and the MEM/WB
// outputs of the memory-stage controller.
//   slave  : controller side (consumes *_IN, drives *_OUT)
//   master : pipeline/memory/testbench side (drives *_IN, observes *_OUT)
// Ports (signals):
//   regWr_IN, memWr_IN, memRd_IN, aluRes_IN, memWrData_IN, rd_IN  EXE/MEM fields
//   memRdData_IN, memAck_IN                                       memory response
//   errClr_IN                                                     sticky error clear
//   memReq_OUT, memWe_OUT, memAddr_OUT, memData_OUT               memory request
//   stall_OUT                                                     upstream hold
//   regWr_OUT, rd_OUT, wbData_OUT                                 MEM/WB fields
//   err_OUT                                                       sticky error flag
// ---------------------------------------------------------------------------
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int REG_W  = 3
);
  logic              regWr_IN;
  logic              memWr_IN;
  logic              memRd_IN;
  logic [DATA_W-1:0] aluRes_IN;
  logic [DATA_W-1:0] memWrData_IN;
  logic [REG_W-1:0]  rd_IN;
  logic [DATA_W-1:0] memRdData_IN;
  logic              memAck_IN;
  logic              errClr_IN;

  logic              memReq_OUT;
  logic              memWe_OUT;
  logic [DATA_W-1:0] memAddr_OUT;
  logic [DATA_W-1:0] memData_OUT;
  logic              stall_OUT;
  logic              regWr_OUT;
  logic [REG_W-1:0]  rd_OUT;
  logic [DATA_W-1:0] wbData_OUT;
  logic              err_OUT;

  modport slave (
    input  regWr_IN, memWr_IN, memRd_IN, aluRes_IN, memWrData_IN, rd_IN,
           memRdData_IN, memAck_IN, errClr_IN,
    output memReq_OUT, memWe_OUT, memAddr_OUT, memData_OUT, stall_OUT,
           regWr_OUT, rd_OUT, wbData_OUT, err_OUT
  );

  modport master (
    output regWr_IN, memWr_IN, memRd_IN, aluRes_IN, memWrData_IN, rd_IN,
           memRdData_IN, memAck_IN, errClr_IN,
    input  memReq_OUT, memWe_OUT, memAddr_OUT, memData_OUT, stall_OUT,
           regWr_OUT, rd_OUT, wbData_OUT, err_OUT
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage controller of the 8-bit pipelined core. ALU results pass to the
// MEM/WB register with one cycle latency; loads/stores are issued to a
// multi-cycle data memory over a req/ack handshake, stalling upstream until
// the access completes or times out after MAX_WAIT wait cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mem_stage_ctrl_if.slave (EXE/MEM inputs, memory bus, MEM/WB outputs)
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int DATA_W   = 8,
  parameter int REG_W    = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_ctrl_if.slave bus
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              memReq_q;
  logic              memWe_q;
  logic [DATA_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memData_q;
  logic              regWr_q;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] wbData_q;
  logic              err_q;
  // write-back control captured with the op, released on read completion
  logic              heldRegWr_q;
  logic [REG_W-1:0]  heldRd_q;

  logic op_s;
  logic last_s;
  logic stall_s;

  assign op_s   = bus.memRd_IN | bus.memWr_IN;
  assign last_s = (cnt_q == CNT_LAST);

  // Upstream stall: high for a new op in IDLE and for every non-final wait cycle.
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      IDLE:             stall_s = op_s;
      RD_WAIT, WR_WAIT: stall_s = ~bus.memAck_IN & ~last_s;
      default:          stall_s = 1'b0;
    endcase
  end

  // Controller FSM with registered memory-bus and MEM/WB outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memData_q   <= '0;
      regWr_q     <= 1'b0;
      rd_q        <= '0;
      wbData_q    <= '0;
      err_q       <= 1'b0;
      heldRegWr_q <= 1'b0;
      heldRd_q    <= '0;
    end else begin
      // Clear first so that any set event later in this block takes priority.
      if (bus.errClr_IN) begin
        err_q <= 1'b0;
      end else begin
        err_q <= err_q;
      end

      case (state_q)
        IDLE: begin
          if (op_s) begin
            memAddr_q   <= bus.aluRes_IN;
            memData_q   <= bus.memWrData_IN;
            heldRegWr_q <= bus.regWr_IN;
            heldRd_q    <= bus.rd_IN;
            memReq_q    <= 1'b1;
            memWe_q     <= bus.memWr_IN;
            cnt_q       <= '0;
            regWr_q     <= 1'b0;
            // a simultaneous read+write request is executed as a write
            state_q     <= bus.memWr_IN ? WR_WAIT : RD_WAIT;
            if (bus.memRd_IN && bus.memWr_IN) begin
              err_q <= 1'b1;
            end
          end else begin
            // ack seen here is stray and deliberately ignored
            regWr_q  <= bus.regWr_IN;
            rd_q     <= bus.rd_IN;
            wbData_q <= bus.aluRes_IN;
          end
        end

        RD_WAIT, WR_WAIT: begin
          if (bus.memAck_IN) begin
            // ack wins over a coinciding timeout
            memReq_q <= 1'b0;
            state_q  <= IDLE;
            if (state_q == RD_WAIT) begin
              regWr_q  <= heldRegWr_q;
              rd_q     <= heldRd_q;
              wbData_q <= bus.memRdData_IN;
            end else begin
              regWr_q <= 1'b0;
            end
          end else if (last_s) begin
            memReq_q <= 1'b0;
            state_q  <= IDLE;
            regWr_q  <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            regWr_q <= 1'b0;
          end
        end

        default: begin
          state_q  <= IDLE;
          memReq_q <= 1'b0;
          regWr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memReq_OUT  = memReq_q;
  assign bus.memWe_OUT   = memWe_q;
  assign bus.memAddr_OUT = memAddr_q;
  assign bus.memData_OUT = memData_q;
  assign bus.stall_OUT   = stall_s;
  assign bus.regWr_OUT   = regWr_q;
  assign bus.rd_OUT      = rd_q;
  assign bus.wbData_OUT  = wbData_q;
  assign bus.err_OUT     = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Self-checking bench for mem_stage_ctrl: a table of per-cycle vectors
// (inputs, expected stall before the edge, expected registers after it) plus
// hand-written sequences for timeout, ack/timeout collision and async reset.
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  localparam int TB_MAX_WAIT = 15;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_stage_ctrl_if #(.DATA_W(8), .REG_W(3)) bus ();

  mem_stage_ctrl #(.DATA_W(8), .REG_W(3), .MAX_WAIT(TB_MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       mr;
    logic [7:0] alu;
    logic [7:0] wd;
    logic [2:0] rd;
    logic [7:0] rdat;
    logic       ack;
    logic       clr;
    logic       e_stall;
    logic       e_req;
    logic       e_we;
    logic [7:0] e_addr;
    logic [7:0] e_data;
    logic       e_rw;
    logic [2:0] e_rd;
    logic [7:0] e_wb;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs on the falling edge, then settle for combinational outputs.
  task automatic drive(input logic rw, input logic mw, input logic mr,
                       input logic [7:0] alu, input logic [7:0] wd,
                       input logic [2:0] rd, input logic [7:0] rdat,
                       input logic ack, input logic clr);
    @(negedge clk);
    bus.regWr_IN     = rw;
    bus.memWr_IN     = mw;
    bus.memRd_IN     = mr;
    bus.aluRes_IN    = alu;
    bus.memWrData_IN = wd;
    bus.rd_IN        = rd;
    bus.memRdData_IN = rdat;
    bus.memAck_IN    = ack;
    bus.errClr_IN    = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.regWr_IN = 1'b0; bus.memWr_IN = 1'b0; bus.memRd_IN = 1'b0;
    bus.aluRes_IN = 8'h00; bus.memWrData_IN = 8'h00; bus.rd_IN = 3'd0;
    bus.memRdData_IN = 8'h00; bus.memAck_IN = 1'b0; bus.errClr_IN = 1'b0;

    //            rw    mw    mr    alu    wd     rd    rdat   ack   clr  | stall req  we    addr   data   rw    rd    wb     err
    vecs.push_back({1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd5, 8'h3C, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd2, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd2, 8'hA5, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h20, 8'h77, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 8'h77, 1'b0, 3'd0, 8'h00, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b0, 8'h20, 8'h77, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd3, 8'h5A, 1'b0});
    vecs.push_back({1'b1, 1'b1, 1'b1, 8'h40, 8'h11, 3'd6, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 8'h11, 1'b0, 3'd0, 8'h00, 1'b1});
    vecs.push_back({1'b1, 1'b1, 1'b1, 8'h40, 8'h11, 3'd6, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1});
    vecs.push_back({1'b1, 1'b0, 1'b0, 8'h99, 8'h00, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd1, 8'h99, 1'b0});
    vecs.push_back({1'b0, 1'b0, 1'b0, 8'h12, 8'h00, 3'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b0, 8'h81, 8'h00, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 3'd7, 8'h81, 1'b0});

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'd0, bus.memReq_OUT}, 32'd0);
    chk("rst_we",    {31'd0, bus.memWe_OUT},  32'd0);
    chk("rst_addr",  {24'd0, bus.memAddr_OUT}, 32'd0);
    chk("rst_data",  {24'd0, bus.memData_OUT}, 32'd0);
    chk("rst_regwr", {31'd0, bus.regWr_OUT},  32'd0);
    chk("rst_rd",    {29'd0, bus.rd_OUT},     32'd0);
    chk("rst_wb",    {24'd0, bus.wbData_OUT}, 32'd0);
    chk("rst_err",   {31'd0, bus.err_OUT},    32'd0);
    chk("rst_stall", {31'd0, bus.stall_OUT},  32'd0);
    @(negedge clk);
    rst = 1'b1;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rw, vecs[i].mw, vecs[i].mr, vecs[i].alu, vecs[i].wd,
            vecs[i].rd, vecs[i].rdat, vecs[i].ack, vecs[i].clr);
      chk($sformatf("v%0d_stall", i), {31'd0, bus.stall_OUT}, {31'd0, vecs[i].e_stall});
      tick();
      chk($sformatf("v%0d_req", i),   {31'd0, bus.memReq_OUT}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_regwr", i), {31'd0, bus.regWr_OUT},  {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_err", i),   {31'd0, bus.err_OUT},    {31'd0, vecs[i].e_err});
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_we", i),   {31'd0, bus.memWe_OUT},   {31'd0, vecs[i].e_we});
        chk($sformatf("v%0d_addr", i), {24'd0, bus.memAddr_OUT}, {24'd0, vecs[i].e_addr});
        chk($sformatf("v%0d_data", i), {24'd0, bus.memData_OUT}, {24'd0, vecs[i].e_data});
      end
      if (vecs[i].e_rw) begin
        chk($sformatf("v%0d_rd", i), {29'd0, bus.rd_OUT},     {29'd0, vecs[i].e_rd});
        chk($sformatf("v%0d_wb", i), {24'd0, bus.wbData_OUT}, {24'd0, vecs[i].e_wb});
      end
    end

    // load that never gets an ack: timeout on the final wait cycle
    drive(1'b1, 1'b0, 1'b1, 8'h33, 8'h00, 3'd4, 8'h00, 1'b0, 1'b0);
    chk("to_op_stall", {31'd0, bus.stall_OUT}, 32'd1);
    tick();
    chk("to_op_req", {31'd0, bus.memReq_OUT}, 32'd1);
    for (int w = 1; w <= TB_MAX_WAIT; w++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h33, 8'h00, 3'd4, 8'h00, 1'b0, 1'b0);
      chk($sformatf("to_w%0d_stall", w), {31'd0, bus.stall_OUT}, (w < TB_MAX_WAIT) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("to_w%0d_req", w), {31'd0, bus.memReq_OUT}, (w < TB_MAX_WAIT) ? 32'd1 : 32'd0);
      chk($sformatf("to_w%0d_regwr", w), {31'd0, bus.regWr_OUT}, 32'd0);
    end
    chk("to_err_set", {31'd0, bus.err_OUT}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
      tick();
      chk($sformatf("to_err_sticky%0d", k), {31'd0, bus.err_OUT}, 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("to_err_clr", {31'd0, bus.err_OUT}, 32'd0);

    // read+write op with clear at the same edge (set wins), then ack on the timeout cycle
    drive(1'b1, 1'b1, 1'b1, 8'h50, 8'hC3, 3'd2, 8'h00, 1'b0, 1'b1);
    chk("both_stall", {31'd0, bus.stall_OUT}, 32'd1);
    tick();
    chk("both_err_setwins", {31'd0, bus.err_OUT},     32'd1);
    chk("both_we",          {31'd0, bus.memWe_OUT},   32'd1);
    chk("both_addr",        {24'd0, bus.memAddr_OUT}, 32'h50);
    chk("both_data",        {24'd0, bus.memData_OUT}, 32'hC3);
    drive(1'b1, 1'b1, 1'b1, 8'h50, 8'hC3, 3'd2, 8'h00, 1'b0, 1'b1);
    tick();
    chk("both_err_clr", {31'd0, bus.err_OUT}, 32'd0);
    for (int w = 2; w < TB_MAX_WAIT; w++) begin
      drive(1'b1, 1'b1, 1'b1, 8'h50, 8'hC3, 3'd2, 8'h00, 1'b0, 1'b0);
      tick();
    end
    chk("both_addr_stable", {24'd0, bus.memAddr_OUT}, 32'h50);
    drive(1'b1, 1'b1, 1'b1, 8'h50, 8'hC3, 3'd2, 8'h00, 1'b1, 1'b0);
    chk("acktimeout_stall", {31'd0, bus.stall_OUT}, 32'd0);
    tick();
    chk("acktimeout_req",   {31'd0, bus.memReq_OUT}, 32'd0);
    chk("acktimeout_err",   {31'd0, bus.err_OUT},    32'd0);
    chk("acktimeout_regwr", {31'd0, bus.regWr_OUT},  32'd0);

    // async reset during RD_WAIT, then a stray ack after release
    drive(1'b1, 1'b0, 1'b1, 8'h66, 8'h00, 3'd3, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 8'h66, 8'h00, 3'd3, 8'h00, 1'b0, 1'b0);
    tick();
    chk("mid_req", {31'd0, bus.memReq_OUT}, 32'd1);
    @(negedge clk);
    bus.regWr_IN = 1'b0; bus.memWr_IN = 1'b0; bus.memRd_IN = 1'b0;
    bus.aluRes_IN = 8'h00; bus.rd_IN = 3'd0;
    rst = 1'b0;
    #1;
    chk("mrst_req",   {31'd0, bus.memReq_OUT}, 32'd0);
    chk("mrst_regwr", {31'd0, bus.regWr_OUT},  32'd0);
    chk("mrst_stall", {31'd0, bus.stall_OUT},  32'd0);
    chk("mrst_addr",  {24'd0, bus.memAddr_OUT}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 8'hEE, 1'b1, 1'b0);
    rst = 1'b1;
    chk("stray_stall", {31'd0, bus.stall_OUT}, 32'd0);
    tick();
    chk("stray_req",   {31'd0, bus.memReq_OUT}, 32'd0);
    chk("stray_regwr", {31'd0, bus.regWr_OUT},  32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'h24, 8'h00, 3'd6, 8'h00, 1'b0, 1'b0);
    tick();
    chk("post_regwr", {31'd0, bus.regWr_OUT},  32'd1);
    chk("post_rd",    {29'd0, bus.rd_OUT},     32'd6);
    chk("post_wb",    {24'd0, bus.wbData_OUT}, 32'h24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
